// File: rtl/tt_response_checker_pkg.sv
// Shared definitions for the truth-table response checker.
//
// Contents:
//   state_e   - checker FSM states (IDLE, ACCEPT, WAIT, DONE)
//   SETTLE_W  - width of the settle-delay down counter (SETTLE is 1..15)
package tt_response_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/tt_coverage.sv
// Row-coverage bitmap for the truth-table checker.
// One bit per truth-table row; a bit is set when that row has been compared.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous reset, active low (clears the bitmap)
//   clr_i        in   clear the whole bitmap (new run); wins over set_i
//   set_i        in   mark row idx_i as covered
//   idx_i        in   row index to mark
//   full_o       out  every row covered (registered bitmap)
//   full_next_o  out  every row will be covered after this edge
module tt_coverage #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            set_i,
    input  logic [N_IN-1:0] idx_i,
    output logic            full_o,
    output logic            full_next_o
);

    localparam int ROWS = 2**N_IN;

    logic [ROWS-1:0] bitmap_q;
    logic [ROWS-1:0] bitmap_d;

    always_comb begin
        bitmap_d = bitmap_q;
        if (clr_i) begin
            bitmap_d = '0;
        end else if (set_i) begin
            bitmap_d[idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitmap_q <= '0;
        end else begin
            bitmap_q <= bitmap_d;
        end
    end

    // The look-ahead lets the FSM leave for DONE on the same edge that
    // completes coverage.
    assign full_o      = &bitmap_q;
    assign full_next_o = &bitmap_d;

endmodule

// File: rtl/tt_response_checker.sv
// Receiving end of a truth-table sweep. Accepts each applied input vector
// via valid/ready, waits SETTLE cycles, samples the DUT output and compares
// it against the EXPECTED table. Counts mismatches (saturating), records the
// first failing vector, tracks row coverage and reports pass/fail.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              pulse: clear results and begin a run (IDLE/DONE only)
//   stop               pulse: end the run early (ACCEPT/WAIT only)
//   in_valid/in_ready  vector handshake; in_ready is high only in ACCEPT
//   in_vec             vector currently driven on the DUT inputs
//   dut_y              DUT output
//   done               run finished, results stable
//   pass               done with full coverage and no mismatches
//   err_count          saturating mismatch count
//   first_fail_valid   a mismatch has been seen this run
//   first_fail_vec     vector of the first mismatch
//   cov_full           every table row has been checked
module tt_response_checker
    import tt_response_checker_pkg::*;
#(
    parameter int                  N_IN     = 4,
    parameter logic [2**N_IN-1:0]  EXPECTED = '0,
    parameter int                  SETTLE   = 1,
    parameter int                  ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             dut_y,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             cov_full
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);
    localparam logic [ERR_W-1:0]    ERR_MAX     = '1;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                ffv_q, ffv_d;
    logic [N_IN-1:0]     ffvec_q, ffvec_d;
    logic                pass_q, pass_d;

    logic start_run;
    logic sample_now;
    logic mismatch;
    logic cov_full_next;

    // A run only (re)starts from IDLE or DONE; start is ignored mid-run.
    assign start_run  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // The comparison edge is the last WAIT cycle; stop discards it.
    assign sample_now = (state_q == ST_WAIT) && !stop && (cnt_q == SETTLE_W'(1));
    assign mismatch   = (dut_y != EXPECTED[vec_q]);

    tt_coverage #(
        .N_IN (N_IN)
    ) u_coverage (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start_run),
        .set_i       (sample_now),
        .idx_i       (vec_q),
        .full_o      (cov_full),
        .full_next_o (cov_full_next)
    );

    // Next-state logic: stop has priority over a handshake or a pending compare.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (in_valid) begin
                    vec_d   = in_vec;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (sample_now) begin
                    state_d = cov_full_next ? ST_DONE : ST_ACCEPT;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result bookkeeping: clear on a new run, count and capture on mismatch.
    always_comb begin
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        if (start_run) begin
            err_d   = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
        end else if (sample_now && mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = vec_q;
            end
        end
        pass_d = (state_d == ST_DONE) && cov_full_next && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            pass_q  <= pass_d;
        end
    end

    assign in_ready         = (state_q == ST_ACCEPT);
    assign done             = (state_q == ST_DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker. Two instances (SETTLE=1 and SETTLE=3, both
// N_IN=3, XOR table, ERR_W=4) are driven independently. An event-level model
// (run active / finished, pending vector with its sample cycle, covered rows,
// unbounded error count) predicts every output and is compared each cycle.
module tb_tt_response_checker;

    localparam logic [7:0] EXP_TABLE = 8'b1001_0110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       startS[2];
    logic       stopS[2];
    logic       inValid[2];
    logic [2:0] inVec[2];
    logic       dutY[2];

    logic       readyO[2];
    logic       doneO[2];
    logic       passO[2];
    logic [3:0] errO[2];
    logic       ffvO[2];
    logic [2:0] ffvecO[2];
    logic       covO[2];

    tt_response_checker #(
        .N_IN(3), .EXPECTED(EXP_TABLE), .SETTLE(1), .ERR_W(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(startS[0]), .stop(stopS[0]),
        .in_valid(inValid[0]), .in_ready(readyO[0]), .in_vec(inVec[0]),
        .dut_y(dutY[0]), .done(doneO[0]), .pass(passO[0]), .err_count(errO[0]),
        .first_fail_valid(ffvO[0]), .first_fail_vec(ffvecO[0]), .cov_full(covO[0])
    );

    tt_response_checker #(
        .N_IN(3), .EXPECTED(EXP_TABLE), .SETTLE(3), .ERR_W(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(startS[1]), .stop(stopS[1]),
        .in_valid(inValid[1]), .in_ready(readyO[1]), .in_vec(inVec[1]),
        .dut_y(dutY[1]), .done(doneO[1]), .pass(passO[1]), .err_count(errO[1]),
        .first_fail_valid(ffvO[1]), .first_fail_vec(ffvecO[1]), .cov_full(covO[1])
    );

    int asserts = 0;
    int fails   = 0;
    bit checkEn = 0;
    int cyc     = 0;
    int dutMode[2];

    bit         mActive[2];
    bit         mFinished[2];
    bit         mPending[2];
    logic [2:0] mVec[2];
    int         mSampleCyc[2];
    int         mErrs[2];
    logic [2:0] mFirst[2];
    logic [7:0] mCov[2];

    function automatic int settleOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic truthOf(input logic [2:0] v);
        return ^v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on every rising edge using the inputs the DUTs see.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mActive[i] = 0; mFinished[i] = 0; mPending[i] = 0;
                mErrs[i] = 0; mFirst[i] = '0; mCov[i] = '0;
            end else if (mActive[i]) begin
                if (stopS[i]) begin
                    mActive[i] = 0; mFinished[i] = 1; mPending[i] = 0;
                end else if (mPending[i]) begin
                    if (cyc == mSampleCyc[i]) begin
                        if (dutY[i] !== truthOf(mVec[i])) begin
                            if (mErrs[i] == 0) mFirst[i] = mVec[i];
                            mErrs[i] = mErrs[i] + 1;
                        end
                        mCov[i][mVec[i]] = 1'b1;
                        mPending[i] = 0;
                        if (mCov[i] == 8'hFF) begin
                            mActive[i] = 0; mFinished[i] = 1;
                        end
                    end
                end else if (inValid[i]) begin
                    mPending[i] = 1;
                    mVec[i] = inVec[i];
                    mSampleCyc[i] = cyc + settleOf(i);
                end
            end else if (startS[i]) begin
                mActive[i] = 1; mFinished[i] = 0;
                mErrs[i] = 0; mFirst[i] = '0; mCov[i] = '0;
            end
        end
    end

    // Compare process: every output of both instances against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("in_ready[%0d]", i), 32'(readyO[i]), 32'(mActive[i] && !mPending[i]));
                checkOutput($sformatf("done[%0d]", i), 32'(doneO[i]), 32'(mFinished[i]));
                checkOutput($sformatf("pass[%0d]", i), 32'(passO[i]),
                            32'(mFinished[i] && (mCov[i] == 8'hFF) && (mErrs[i] == 0)));
                checkOutput($sformatf("err_count[%0d]", i), 32'(errO[i]), (mErrs[i] > 15) ? 32'd15 : 32'(mErrs[i]));
                checkOutput($sformatf("first_fail_valid[%0d]", i), 32'(ffvO[i]), 32'(mErrs[i] > 0));
                checkOutput($sformatf("first_fail_vec[%0d]", i), 32'(ffvecO[i]), 32'(mFirst[i]));
                checkOutput($sformatf("cov_full[%0d]", i), 32'(covO[i]), 32'(mCov[i] == 8'hFF));
            end
        end
    end

    // Behavioural DUT-under-test: mode 4 glitches except just before the sample edge.
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            case (dutMode[i])
                0: dutY[i] = ^inVec[i];
                1: dutY[i] = 1'b0;
                2: dutY[i] = 1'b1;
                3: dutY[i] = 1'($urandom % 2);
                default: dutY[i] = (mPending[i] && (mSampleCyc[i] == cyc + 1)) ? ^inVec[i] : 1'($urandom % 2);
            endcase
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic startPulse(input int i);
        startS[i] = 1'b1;
        nextCycle();
        startS[i] = 1'b0;
    endtask

    task automatic stopPulse(input int i);
        stopS[i] = 1'b1;
        nextCycle();
        stopS[i] = 1'b0;
    endtask

    task automatic waitReady(input int i);
        int n = 0;
        while (readyO[i] !== 1'b1 && n < 40) begin
            nextCycle();
            n++;
        end
        checkOutput($sformatf("ready reached[%0d]", i), 32'(readyO[i]), 32'd1);
    endtask

    task automatic waitDone(input int i);
        int n = 0;
        while (doneO[i] !== 1'b1 && n < 40) begin
            nextCycle();
            n++;
        end
        checkOutput($sformatf("done reached[%0d]", i), 32'(doneO[i]), 32'd1);
    endtask

    // Present one vector; the vector only changes once the checker is ready,
    // so the DUT inputs stay steady through the settle window.
    task automatic applyStimulus(input int i, input logic [2:0] v);
        waitReady(i);
        inVec[i]   = v;
        inValid[i] = 1'b1;
        nextCycle();
    endtask

    task automatic runXorSweep();
        dutMode[0] = 0;
        startPulse(0);
        for (int v = 0; v < 8; v++) applyStimulus(0, 3'(v));
        inValid[0] = 1'b0;
        checkOutput("sweep done before last compare", 32'(doneO[0]), 32'd0);
        nextCycle();
        checkOutput("sweep done", 32'(doneO[0]), 32'd1);
        checkOutput("sweep pass", 32'(passO[0]), 32'd1);
        checkOutput("sweep err_count", 32'(errO[0]), 32'd0);
        checkOutput("sweep cov_full", 32'(covO[0]), 32'd1);
    endtask

    initial begin
        int tFirst, tLast;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            startS[i] = 0; stopS[i] = 0; inValid[i] = 0; inVec[i] = '0; dutMode[i] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        rst_n   = 1'b1;
        checkEn = 1;
        checkOutput("reset done", 32'(doneO[0]), 32'd0);
        checkOutput("reset in_ready", 32'(readyO[0]), 32'd0);
        checkOutput("reset err_count", 32'(errO[0]), 32'd0);

        $display("[TB] correct XOR sweep");
        runXorSweep();

        $display("[TB] stuck-at-0 sweep");
        dutMode[0] = 1;
        startPulse(0);
        for (int v = 0; v < 8; v++) applyStimulus(0, 3'(v));
        inValid[0] = 1'b0;
        waitDone(0);
        checkOutput("stuck0 err_count", 32'(errO[0]), 32'd4);
        checkOutput("stuck0 first_fail_vec", 32'(ffvecO[0]), 32'd1);
        checkOutput("stuck0 first_fail_valid", 32'(ffvO[0]), 32'd1);
        checkOutput("stuck0 pass", 32'(passO[0]), 32'd0);

        $display("[TB] early stop, stop with handshake");
        dutMode[0] = 0;
        startPulse(0);
        for (int v = 0; v < 6; v++) applyStimulus(0, 3'(v));
        applyStimulus(0, 3'd7);
        inValid[0] = 1'b0;
        waitReady(0);
        inVec[0] = 3'd6; inValid[0] = 1'b1; stopS[0] = 1'b1;
        nextCycle();
        inValid[0] = 1'b0; stopS[0] = 1'b0;
        checkOutput("stop done", 32'(doneO[0]), 32'd1);
        checkOutput("stop cov_full", 32'(covO[0]), 32'd0);
        checkOutput("stop pass", 32'(passO[0]), 32'd0);
        checkOutput("stop err_count", 32'(errO[0]), 32'd0);

        $display("[TB] SETTLE=3 throughput with glitching output");
        dutMode[1] = 4;
        startPulse(1);
        tFirst = 0; tLast = 0;
        for (int v = 0; v < 8; v++) begin
            applyStimulus(1, 3'(v));
            if (v == 0) tFirst = cyc;
            tLast = cyc;
        end
        inValid[1] = 1'b0;
        checkOutput("settle3 accept spacing", 32'(tLast - tFirst), 32'd28);
        waitDone(1);
        checkOutput("settle3 pass", 32'(passO[1]), 32'd1);
        checkOutput("settle3 err_count", 32'(errO[1]), 32'd0);

        $display("[TB] saturation with repeated vector");
        dutMode[0] = 2;
        startPulse(0);
        repeat (20) applyStimulus(0, 3'd0);
        inValid[0] = 1'b0;
        nextCycle();
        checkOutput("sat err_count", 32'(errO[0]), 32'd15);
        checkOutput("sat cov_full", 32'(covO[0]), 32'd0);
        checkOutput("sat first_fail_vec", 32'(ffvecO[0]), 32'd0);
        checkOutput("sat done", 32'(doneO[0]), 32'd0);
        stopPulse(0);
        checkOutput("sat stop done", 32'(doneO[0]), 32'd1);

        $display("[TB] reset during WAIT");
        dutMode[0] = 0;
        startPulse(0);
        applyStimulus(0, 3'd3);
        inValid[0] = 1'b0;
        rst_n = 1'b0;
        nextCycle();
        checkOutput("rst in_ready", 32'(readyO[0]), 32'd0);
        checkOutput("rst done", 32'(doneO[0]), 32'd0);
        checkOutput("rst pass", 32'(passO[0]), 32'd0);
        checkOutput("rst err_count", 32'(errO[0]), 32'd0);
        checkOutput("rst first_fail_valid", 32'(ffvO[0]), 32'd0);
        checkOutput("rst cov_full", 32'(covO[0]), 32'd0);
        rst_n = 1'b1;
        runXorSweep();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2; i++) dutMode[i] = 3;
        repeat (900) begin
            for (int i = 0; i < 2; i++) begin
                inValid[i] = 1'($urandom % 2);
                inVec[i]   = 3'($urandom % 8);
                startS[i]  = ($urandom % 8) == 0;
                stopS[i]   = ($urandom % 100) == 0;
            end
            nextCycle();
        end
        for (int i = 0; i < 2; i++) begin
            inValid[i] = 0; startS[i] = 0; stopS[i] = 0;
        end
        repeat (5) nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
